// File: rtl/vga_sprite_renderer_if.sv
// ============================================================================
// Module   : vga_sprite_renderer_if
// Purpose  : Sprite-position handshake between game logic and the renderer.
//            The game logic offers a new top-left position (posX, posY) with
//            posValid. The renderer accepts it on a clock edge where both
//            posValid and posReady are high.
// Signals  : posValid  - new position offered (master -> slave)
//            posReady  - renderer can accept a position (slave -> master)
//            posX/posY - requested sprite top-left corner, 10 bits each
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sprite_renderer_if;
  logic       posValid;
  logic       posReady;
  logic [9:0] posX;
  logic [9:0] posY;

  modport master (output posValid, output posX, output posY, input  posReady);
  modport slave  (input  posValid, input  posX, input  posY, output posReady);
endinterface

`default_nettype wire

// File: rtl/vga_sprite_renderer.sv
// ============================================================================
// Module   : vga_sprite_renderer
// Purpose  : Pixel source for the VGA controller. Composites a 16x16 sprite
//            with clipped corners over a checkerboard background. The
//            latency from pixel coordinate to RGB is fixed at 2 cycles.
//            Sprite position updates are double-buffered and take effect
//            only at frame start, so a visible frame never tears.
// Ports    : clk        - pixel clock
//            rstN       - asynchronous active-low reset
//            pixelX/Y   - current pixel coordinate (10 bits each)
//            videoOn    - coordinate lies inside the visible area
//            frameStart - one-cycle pulse at the start of vertical blanking
//            pos        - position handshake (slave side)
//            outRed/outGreen/outBlue - 8-bit colour channels
//            outValid   - videoOn aligned with the RGB outputs
//            frameCount - number of frameStart pulses since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sprite_renderer #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          INIT_X     = 312,
  parameter int          INIT_Y     = 232,
  parameter int          TILE_LOG2  = 5,
  parameter logic [23:0] SPRITE_RGB = 24'hFF0000,
  parameter logic [23:0] BG_A_RGB   = 24'h202020,
  parameter logic [23:0] BG_B_RGB   = 24'h404040
) (
  input  wire logic                  clk,
  input  wire logic                  rstN,
  input  wire logic [9:0]            pixelX,
  input  wire logic [9:0]            pixelY,
  input  wire logic                  videoOn,
  input  wire logic                  frameStart,
  vga_sprite_renderer_if.slave       pos,
  output logic [7:0]                 outRed,
  output logic [7:0]                 outGreen,
  output logic [7:0]                 outBlue,
  output logic                       outValid,
  output logic [15:0]                frameCount
);

  localparam logic [9:0]  C_INIT_X    = 10'(INIT_X);
  localparam logic [9:0]  C_INIT_Y    = 10'(INIT_Y);
  localparam logic [10:0] C_H_ACTIVE  = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACTIVE  = 11'(V_ACTIVE);
  localparam logic [10:0] C_SPRITE_SZ = 11'd16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Position handshake and double buffering
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [9:0] shadowX_q, shadowX_d;
  logic [9:0] shadowY_q, shadowY_d;
  logic [9:0] activeX_q, activeX_d;
  logic [9:0] activeY_q, activeY_d;
  logic       posReady_q;
  logic [15:0] frameCount_q;
  logic       accept;

  // posReady is a register so that it reads 0 throughout reset and rises on
  // the first edge after release; a position is only taken when it is high.
  assign accept       = pos.posValid && posReady_q;
  assign pos.posReady = posReady_q;
  assign frameCount   = frameCount_q;

  always_comb begin
    state_d   = state_q;
    shadowX_d = shadowX_q;
    shadowY_d = shadowY_q;
    activeX_d = activeX_q;
    activeY_d = activeY_q;
    case (state_q)
      IDLE: begin
        // A frameStart on the accepting edge does not apply the new position;
        // it waits for the following frameStart.
        if (accept) begin
          shadowX_d = pos.posX;
          shadowY_d = pos.posY;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (frameStart) begin
          activeX_d = shadowX_q;
          activeY_d = shadowY_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      shadowX_q    <= '0;
      shadowY_q    <= '0;
      activeX_q    <= C_INIT_X;
      activeY_q    <= C_INIT_Y;
      posReady_q   <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q    <= state_d;
      shadowX_q  <= shadowX_d;
      shadowY_q  <= shadowY_d;
      activeX_q  <= activeX_d;
      activeY_q  <= activeY_d;
      posReady_q <= (state_d == IDLE);
      if (frameStart) begin
        frameCount_q <= frameCount_q + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: sprite hit test, sprite-local offset, tile parity
  // --------------------------------------------------------------------------
  logic [10:0] px, py, sx, sy;
  logic        inSprite;
  logic        visible;
  logic [3:0]  dx, dy;
  logic        parity;

  // 11-bit compares so sx+16 never wraps: sprites near 1023 simply clip.
  assign px = {1'b0, pixelX};
  assign py = {1'b0, pixelY};
  assign sx = {1'b0, activeX_q};
  assign sy = {1'b0, activeY_q};

  assign inSprite = (px >= sx) && (px < sx + C_SPRITE_SZ) &&
                    (py >= sy) && (py < sy + C_SPRITE_SZ);
  assign dx       = pixelX[3:0] - activeX_q[3:0];
  assign dy       = pixelY[3:0] - activeY_q[3:0];
  assign parity   = pixelX[TILE_LOG2] ^ pixelY[TILE_LOG2];

  // Guard against a timing source asserting videoOn outside the active area.
  assign visible  = videoOn && (px < C_H_ACTIVE) && (py < C_V_ACTIVE);

  logic       s1InSprite_q;
  logic [3:0] s1Dx_q, s1Dy_q;
  logic       s1Parity_q;
  logic       s1Video_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1InSprite_q <= 1'b0;
      s1Dx_q       <= '0;
      s1Dy_q       <= '0;
      s1Parity_q   <= 1'b0;
      s1Video_q    <= 1'b0;
    end else begin
      s1InSprite_q <= inSprite;
      s1Dx_q       <= dx;
      s1Dy_q       <= dy;
      s1Parity_q   <= parity;
      s1Video_q    <= visible;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: corner mask, colour select, blanking
  // --------------------------------------------------------------------------
  logic        cornerX, cornerY, spriteOpaque;
  logic [23:0] colour;

  assign cornerX      = (s1Dx_q == 4'd0) || (s1Dx_q == 4'd15);
  assign cornerY      = (s1Dy_q == 4'd0) || (s1Dy_q == 4'd15);
  assign spriteOpaque = s1InSprite_q && !(cornerX && cornerY);

  always_comb begin
    colour = BG_A_RGB;
    if (!s1Video_q) begin
      colour = 24'h000000;
    end else if (spriteOpaque) begin
      colour = SPRITE_RGB;
    end else if (s1Parity_q) begin
      colour = BG_B_RGB;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outRed   <= '0;
      outGreen <= '0;
      outBlue  <= '0;
      outValid <= 1'b0;
    end else begin
      outRed   <= colour[23:16];
      outGreen <= colour[15:8];
      outBlue  <= colour[7:0];
      outValid <= s1Video_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sprite_renderer.sv
// ============================================================================
// Module   : tb_vga_sprite_renderer
// Purpose  : Self-checking bench for vga_sprite_renderer. Pixel stimulus
//            pushes expected colours into a scoreboard queue; a monitor pops
//            and compares when the tagged pixel reaches the outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sprite_renderer;

  logic        clk;
  logic        rstN;
  logic [9:0]  pixelX, pixelY;
  logic        videoOn, frameStart;
  logic [7:0]  outRed, outGreen, outBlue;
  logic        outValid;
  logic [15:0] frameCount;

  vga_sprite_renderer_if pos_if ();

  vga_sprite_renderer dut (
    .clk        (clk),
    .rstN       (rstN),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .videoOn    (videoOn),
    .frameStart (frameStart),
    .pos        (pos_if.slave),
    .outRed     (outRed),
    .outGreen   (outGreen),
    .outBlue    (outBlue),
    .outValid   (outValid),
    .frameCount (frameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Tag travels alongside a checked pixel through the 2-cycle pipeline.
  logic chk_drv = 1'b0;
  logic chk_d1  = 1'b0;
  logic chk_d2  = 1'b0;

  always @(posedge clk) begin
    chk_d1 <= chk_drv;
    chk_d2 <= chk_d1;
  end

  always @(negedge clk) begin
    if (chk_d2) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_out: output arrived but no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({outRed, outGreen, outBlue} !== e.rgb || outValid !== e.vld) begin
          errors++;
          $display("FAIL pixel_out: got rgb=%06h valid=%0b, expected rgb=%06h valid=%0b",
                   {outRed, outGreen, outBlue}, outValid, e.rgb, e.vld);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one checked pixel for one cycle.
  task automatic pix(input int x, input int y, input logic vo, input logic [23:0] rgb);
    exp_t e;
    pixelX  = 10'(x);
    pixelY  = 10'(y);
    videoOn = vo;
    chk_drv = 1'b1;
    e.rgb   = vo ? rgb : 24'h0;
    e.vld   = vo;
    exp_q.push_back(e);
    @(negedge clk);
    chk_drv = 1'b0;
    videoOn = 1'b0;
  endtask

  task automatic idle(input int n);
    chk_drv = 1'b0;
    videoOn = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int x, input int y);
    pos_if.posValid = 1'b1;
    pos_if.posX     = 10'(x);
    pos_if.posY     = 10'(y);
    @(negedge clk);
    pos_if.posValid = 1'b0;
  endtask

  task automatic frame_pulse();
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] BGA = 24'h202020;
  localparam logic [23:0] BGB = 24'h404040;

  initial begin
    rstN            = 1'b0;
    pixelX          = '0;
    pixelY          = '0;
    videoOn         = 1'b0;
    frameStart      = 1'b0;
    pos_if.posValid = 1'b0;
    pos_if.posX     = '0;
    pos_if.posY     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rgb", {8'h0, outRed, outGreen, outBlue}, 32'h0);
    check("reset_valid", {31'h0, outValid}, 32'h0);
    check("reset_ready", {31'h0, pos_if.posReady}, 32'h0);
    check("reset_fcount", {16'h0, frameCount}, 32'h0);
    rstN = 1'b1;

    // First pixel after release; ready rises on the first edge
    pix(0, 0, 1'b1, BGA);
    check("ready_after_release", {31'h0, pos_if.posReady}, 32'h1);
    check("fcount_after_release", {16'h0, frameCount}, 32'h0);
    idle(2);

    // Default sprite at (312,232): corner transparent, neighbour red
    pix(312, 232, 1'b1, BGA);
    pix(313, 232, 1'b1, RED);
    pix(328, 240, 1'b1, BGB);
    idle(2);

    // Handshake: position applied only after frameStart
    offer(100, 50);
    check("ready_pending", {31'h0, pos_if.posReady}, 32'h0);
    pix(101, 50, 1'b1, BGA);
    idle(2);
    frame_pulse();
    check("ready_after_frame", {31'h0, pos_if.posReady}, 32'h1);
    check("fcount_1", {16'h0, frameCount}, 32'h1);
    pix(101, 50, 1'b1, RED);
    idle(2);

    // posValid with frameStart on the same edge: applied one frame later
    pos_if.posValid = 1'b1;
    pos_if.posX     = 10'd200;
    pos_if.posY     = 10'd200;
    frameStart      = 1'b1;
    @(negedge clk);
    pos_if.posValid = 1'b0;
    frameStart      = 1'b0;
    check("ready_same_edge", {31'h0, pos_if.posReady}, 32'h0);
    check("fcount_2", {16'h0, frameCount}, 32'h2);
    pix(201, 200, 1'b1, BGA);
    pix(101, 50, 1'b1, RED);
    idle(2);
    frame_pulse();
    pix(201, 200, 1'b1, RED);
    idle(2);

    // Clipped sprite at the bottom-right corner, plus blanking
    offer(630, 470);
    frame_pulse();
    pix(639, 479, 1'b1, RED);
    pix(630, 470, 1'b1, BGB);
    pix(639, 479, 1'b0, 24'h0);
    idle(2);
    check("fcount_4", {16'h0, frameCount}, 32'h4);

    // frameCount wrap: 65532 more pulses reach 65536 in total
    frameStart = 1'b1;
    repeat (65531) @(negedge clk);
    check("fcount_ffff", {16'h0, frameCount}, 32'hFFFF);
    @(negedge clk);
    frameStart = 1'b0;
    check("fcount_wrap", {16'h0, frameCount}, 32'h0);

    // Reset while PENDING, with live pixels in the pipeline
    offer(10, 10);
    check("ready_pending2", {31'h0, pos_if.posReady}, 32'h0);
    pixelX  = 10'd320;
    pixelY  = 10'd240;
    videoOn = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_red", {24'h0, outRed}, 32'h40);
    #2 rstN = 1'b0;
    #1;
    check("async_reset_rgb", {8'h0, outRed, outGreen, outBlue}, 32'h0);
    check("async_reset_valid", {31'h0, outValid}, 32'h0);
    check("async_reset_ready", {31'h0, pos_if.posReady}, 32'h0);
    videoOn = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    idle(1);
    frame_pulse();
    check("ready_post_reset", {31'h0, pos_if.posReady}, 32'h1);
    check("fcount_post_reset", {16'h0, frameCount}, 32'h1);
    pix(313, 232, 1'b1, RED);
    pix(11, 10, 1'b1, BGA);
    idle(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
